mod_addsub_vec: RTL
===================

Name: mod_addsub_vec

Overview:
- Sequential, multi-lane successor to the combinational modular adder. Computes a±b mod Q over LANES parallel lanes, W bits per lane.
- Runs as a job: `start` latches Q, mode and an element count. The block then consumes LEN operand beats, emits one result beat per operand beat through a 2-stage pipeline, and pulses `done` once the last result is out.
- Sits between the key-generation datapath and the polynomial buffers. Used for coefficient-wise add/sub/negate in Z_Q.

Parameters:
- W, 32, lane data width in bits.
- LANES, 4, parallel coefficient lanes per beat.
- CNT_W, 16, width of the element-count field; max job length 2^CNT_W-1 beats.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  job request; accepted only when ready=1.
- mode  input  2  00 add, 01 sub (a-b), 10 negate (Q-b, a ignored), 11 reduce (a mod Q, single correction); latched on start.
- len  input  CNT_W  beats in the job; latched on start.
- Q  input  W  modulus, unsigned, 2 ≤ Q ≤ 2^W-1; latched on start.
- in_valid  input  1  operand beat present.
- a  input  LANES*W  operand A; lane i is bits [i*W+W-1 : i*W].
- b  input  LANES*W  operand B; same lane packing as a.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- out_valid  output  1  result beat valid; single-cycle per beat, no backpressure.
- out  output  LANES*W  result lanes, same packing as a.
- ready  output  1  idle; a new job may start.
- done  output  1  one-cycle pulse after the last result beat of a job.

Behaviour:
- Reset (rst=0, async): state IDLE, ready=1, in_ready=0, out_valid=0, out=0, done=0, counters=0, both pipeline valid bits=0. Reset mid-job aborts the job; no done is issued.
- FSM states:
  - IDLE: ready=1. On start: latch Q/mode/len, set rem=len. If len=0, go to FIN; else go to RUN.
  - RUN: in_ready=1. Each accepted beat decrements rem. When the beat with rem=1 is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. Inputs Q/mode/len are don't-care except in the cycle start is accepted.
- Operands are unsigned and required to lie in [0,Q).
- Stage 1 (register), per lane:
  - add: s=a+b in W+1 bits.
  - sub: s=a-b in W+1 bits, borrow = bit W.
  - neg: s=Q-b.
  - reduce: s=a.
- Stage 2 (register), per lane:
  - add/reduce: out = s≥Q ? s-Q : s.
  - sub: out = borrow ? s+Q (low W bits) : s.
  - neg: out = (b==0) ? 0 : s.
- Latency: an accepted beat produces out_valid exactly 2 cycles later. Throughput is 1 beat/cycle; in_valid gaps propagate as out_valid gaps.
- done timing: done asserts the cycle after the final out_valid. For len=0, done asserts 2 cycles after start.
- Out-of-range operands get a single correction only. The result is unspecified-but-deterministic and must not hang the FSM.
- out holds its last value when out_valid=0.

Test Plan:
- Add, single lane check, len=1: a lane0=0x07FFF800, b=0x00000200, Q=0x07FFF801, mode=00 -> out lane0=0x000001FF two cycles after accept; done one cycle after that; ready returns 1.
- Sub wrap, len=1, Q=17: lanes a={3,16,0,5}, b={5,16,1,0}, mode=01 -> out={15,0,16,5}.
- Negate and reduce, Q=97:
  - mode=10, b={0,1,96,50} -> out={0,96,1,47}.
  - Second job mode=11, a={96,0,50,96} -> out=a unchanged (all lanes already <Q).
- Streaming with gaps, len=4, mode=00, Q=0xFFFFFFFF: a lane=0xFFFFFFFE, b lane=0x00000001, in_valid pattern 1,0,1,1,0,1 -> out=0 on every lane; 4 out_valid pulses, each 2 cycles after its accept; in_ready drops after the 4th accept; exactly one done.
- Boundaries:
  - len=0 -> no out_valid; done 2 cycles after start.
  - start asserted during RUN -> ignored, rem unaffected.
- Reset mid-job, len=8: assert rst=0 after 3 beats -> outputs zero immediately (async); no done; after release ready=1, and a fresh len=1 add job completes correctly.

Source files
------------

// File: rtl/mod_addsub_vec.sv
// Multi-lane modular add/sub/negate/reduce over Z_Q, run as length-counted jobs.
// Each accepted operand beat yields one result beat two cycles later through a 2-stage pipeline.
module mod_addsub_vec #(
  parameter int W     = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   len,
  input  logic [W-1:0]       Q,
  input  logic               in_valid,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               in_ready,
  output logic               out_valid,
  output logic [LANES*W-1:0] out,
  output logic               ready,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_NEG = 2'b10, OP_RED = 2'b11} op_t;

  state_t           state, state_next;
  op_t              op_reg;
  logic [W-1:0]     q_reg;
  logic [CNT_W-1:0] rem;
  logic             accept;
  logic             v1;
  logic [W:0]       s_next [LANES];
  logic [W:0]       s      [LANES];
  logic [LANES-1:0] bz;
  logic [W-1:0]     r_next [LANES];

  assign accept = in_valid && in_ready;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = (len == '0) ? FIN : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && rem == CNT_W'(1)) state_next = DRAIN;
      end
      // The final beat is in stage 1 on entry; done is registered out of FIN,
      // so it lands in the cycle after that beat leaves stage 2.
      DRAIN:   state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_reg <= OP_ADD;
      q_reg  <= '0;
      rem    <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FIN);
      if (state == IDLE && start) begin
        q_reg  <= Q;
        op_reg <= op_t'(mode);
        rem    <= len;
      end else if (accept) begin
        rem <= rem - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s_next[i] = '0;
      case (op_reg)
        OP_ADD:  s_next[i] = {1'b0, a[i*W +: W]} + {1'b0, b[i*W +: W]};
        OP_SUB:  s_next[i] = {1'b0, a[i*W +: W]} - {1'b0, b[i*W +: W]};
        OP_NEG:  s_next[i] = {1'b0, q_reg} - {1'b0, b[i*W +: W]};
        default: s_next[i] = {1'b0, a[i*W +: W]};
      endcase
    end
  end

  // Single conditional correction; bit W of s is the borrow for subtraction.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      r_next[i] = s[i][W-1:0];
      case (op_reg)
        OP_SUB:  if (s[i][W]) r_next[i] = W'(s[i] + {1'b0, q_reg});
        OP_NEG:  if (bz[i]) r_next[i] = '0;
        default: if (s[i] >= {1'b0, q_reg}) r_next[i] = W'(s[i] - {1'b0, q_reg});
      endcase
    end
  end

  // NOTE: datapath registers are reset too, because out must read zero during and after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      bz        <= '0;
      out       <= '0;
      for (int i = 0; i < LANES; i++) s[i] <= '0;
    end else begin
      v1        <= accept;
      out_valid <= v1;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          s[i]  <= s_next[i];
          bz[i] <= (b[i*W +: W] == '0);
        end
      end
      if (v1) begin
        for (int i = 0; i < LANES; i++) out[i*W +: W] <= r_next[i];
      end
    end
  end

endmodule
